// File: rtl/ram_access_unit.sv
// Load/store bridge onto one port of a byte-write data RAM: column enables, lane-aligned loads,
// in-order responses with a small skid FIFO. Define AURORA_RAM_RANGE_CHECK_EN to flag out-of-range addresses.
module ram_access_unit #(
  parameter int unsigned RAM_DEPTH = 16384,
  parameter int unsigned LATENCY   = 1,
  localparam int unsigned AW       = $clog2(RAM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_error,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_din,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  input  logic [31:0]   ram_dout
);

  localparam int unsigned D  = LATENCY + 1;
  localparam int unsigned PW = $clog2(D);
  localparam int unsigned CW = $clog2(2 * D + 1);

  if (LATENCY < 1 || LATENCY > 2) begin : gen_bad_latency
    $error("ram_access_unit: LATENCY must be 1 or 2");
  end

  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       uns;
    logic       we;
    logic       err;
  } tag_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic          size_err, misalign, range_err, req_err, accept;
  logic [3:0]    wmask;
  logic          unused_addr;

  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  tag_t               pipe_tag_q [LATENCY];
  tag_t               pipe_tag_d [LATENCY];

  logic          exit_vld;
  tag_t          exit_tag;
  rsp_t          exit_rsp;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [31:0]   fmt_data;

  rsp_t          fifo_q [D];
  rsp_t          fifo_d [D];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] inflight, outstanding;
  logic          fifo_empty, push, pop;
  rsp_t          rsp_sel;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request decode and the RAM side, combinational from the request
  always_comb begin
    size_err = (req_size == 2'b11);
    misalign = ((req_size == 2'b01) && req_addr[0]) ||
               ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef AURORA_RAM_RANGE_CHECK_EN
    range_err = (req_addr >> (AW + 2)) != 32'd0;
`else
    range_err = 1'b0;
`endif
    req_err = size_err | misalign | range_err;
    // Held reset must keep the RAM quiet even though req_ready reads 1
    accept  = req_valid & req_ready & rst;
  end

  assign unused_addr = ^req_addr[31:AW+2];
  assign ram_addr    = req_addr[AW+1:2];

  always_comb begin
    wmask   = 4'b0000;
    ram_din = req_wdata;
    case (req_size)
      2'b00: begin
        wmask   = 4'b0001 << req_addr[1:0];
        ram_din = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wmask   = 4'b0011 << req_addr[1:0];
        ram_din = {2{req_wdata[15:0]}};
      end
      2'b10:   wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase
    ram_en = accept & ~req_err;
    ram_we = (ram_en & req_we) ? wmask : 4'b0000;
  end

  // Tag pipeline tracks each accepted request across the RAM read latency
  always_comb begin
    pipe_vld_d[0]      = accept;
    pipe_tag_d[0].off  = req_addr[1:0];
    pipe_tag_d[0].size = req_size;
    pipe_tag_d[0].uns  = req_unsigned;
    pipe_tag_d[0].we   = req_we;
    pipe_tag_d[0].err  = req_err;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_tag_d[i] = pipe_tag_q[i-1];
    end
  end

  assign exit_vld = pipe_vld_q[LATENCY-1];
  assign exit_tag = pipe_tag_q[LATENCY-1];

  always_comb begin
    lane_byte = ram_dout[{exit_tag.off, 3'b000} +: 8];
    lane_half = exit_tag.off[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (exit_tag.size)
      2'b00:   fmt_data = {{24{~exit_tag.uns & lane_byte[7]}}, lane_byte};
      2'b01:   fmt_data = {{16{~exit_tag.uns & lane_half[15]}}, lane_half};
      2'b10:   fmt_data = ram_dout;
      default: fmt_data = 32'd0;
    endcase
    if (exit_tag.we || exit_tag.err) begin
      fmt_data = 32'd0;
    end
    exit_rsp.err  = exit_tag.err;
    exit_rsp.data = fmt_data;
  end

  // Response path: FIFO head has priority, otherwise the exiting tag bypasses
  always_comb begin
    fifo_empty = (cnt_q == '0);
    pop        = ~fifo_empty & rsp_ready;
    push       = exit_vld & ~(fifo_empty & rsp_ready);

    if (!fifo_empty) begin
      rsp_valid = 1'b1;
      rsp_sel   = fifo_q[rd_ptr_q];
    end else if (exit_vld) begin
      rsp_valid = 1'b1;
      rsp_sel   = exit_rsp;
    end else begin
      rsp_valid = 1'b0;
      rsp_sel   = '0;
    end
    rsp_rdata = rsp_sel.data;
    rsp_error = rsp_sel.err;
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = exit_rsp;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Admission uses registered state only, so rsp_ready never reaches req_ready
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + CW'(pipe_vld_q[i]);
    end
    outstanding = inflight + cnt_q;
    req_ready   = (outstanding < CW'(D));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_tag_q[i] <= '0;
      end
      for (int i = 0; i < D; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_tag_q <= pipe_tag_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ram_access_unit.sv
// Randomized bench for ram_access_unit: byte-array reference memory and an in-order expected
// response queue predict RAM controls, admission, response timing and load data.
module tb_ram_access_unit;

  localparam int unsigned RamDepth = 16384;
  localparam int unsigned Latency  = 2;
  localparam int unsigned Aw       = $clog2(RamDepth);
  localparam int unsigned Depth    = Latency + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [31:0]   req_addr, req_wdata;
  logic [1:0]    req_size;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [31:0]   rsp_rdata;
  logic [Aw-1:0] ram_addr;
  logic [31:0]   ram_din, ram_dout;
  logic          ram_en;
  logic [3:0]    ram_we;

  always #5 clk = ~clk;

  ram_access_unit #(
    .RAM_DEPTH(RamDepth),
    .LATENCY  (Latency)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_dout    (ram_dout)
  );

  // Behavioural byte-write RAM, read-first, Latency cycles of read delay
  logic [31:0] mem [RamDepth] = '{default: 32'h0};
  logic [31:0] rd1 = '0;
  logic [31:0] rd2 = '0;
  always @(posedge clk) begin
    if (ram_en) begin
      rd1 <= mem[ram_addr];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end
    end
    rd2 <= rd1;
  end
  assign ram_dout = (Latency == 1) ? rd1 : rd2;

  // Reference model state
  logic [7:0] ref_mem [RamDepth*4] = '{default: 8'h0};
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;
  exp_t exp_q[$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cycle    = 0;
  int unsigned n_acc    = 0;
  int unsigned n_pop    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic int unsigned size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  logic        m_acc, m_err, m_exp_valid;
  int unsigned m_nb, m_off, m_word;
  logic [31:0] m_mask, m_din, m_val;
  exp_t        m_e;

  always @(negedge clk) begin
    if (rst) begin
      cycle++;
      m_acc = req_valid && req_ready;
      check_eq("req_ready", 32'(req_ready), 32'(exp_q.size() < Depth));

      m_nb  = size_bytes(req_size);
      m_err = (m_nb == 0) || ((req_addr % m_nb) != 0);
`ifdef AURORA_RAM_RANGE_CHECK_EN
      if ((req_addr >> (Aw + 2)) != 0) m_err = 1'b1;
`endif
      m_off  = req_addr % 4;
      m_word = (req_addr / 4) % RamDepth;

      check_eq("ram_en", 32'(ram_en), 32'(m_acc && !m_err));
      if (m_acc && !m_err) begin
        check_eq("ram_addr", 32'(ram_addr), m_word);
        if (req_we) begin
          m_mask = ((32'd1 << m_nb) - 1) << m_off;
          m_din  = (m_nb == 1) ? req_wdata[7:0] * 32'h0101_0101 :
                   (m_nb == 2) ? req_wdata[15:0] * 32'h0001_0001 : req_wdata;
          check_eq("ram_we", 32'(ram_we), m_mask);
          check_eq("ram_din", ram_din, m_din);
        end else begin
          check_eq("ram_we_load", 32'(ram_we), 32'd0);
        end
      end else begin
        check_eq("ram_we_idle", 32'(ram_we), 32'd0);
      end

      m_exp_valid = (exp_q.size() > 0) && (cycle >= exp_q[0].cyc + Latency);
      check_eq("rsp_valid", 32'(rsp_valid), 32'(m_exp_valid));
      if (rsp_valid && m_exp_valid) begin
        check_eq("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        check_eq("rsp_error", 32'(rsp_error), 32'(exp_q[0].err));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end

      if (m_acc) begin
        n_acc++;
        m_e.err   = m_err;
        m_e.rdata = 32'd0;
        m_e.cyc   = cycle;
        if (!m_err) begin
          if (req_we) begin
            for (int k = 0; k < int'(m_nb); k++) begin
              ref_mem[m_word*4 + m_off + k] = req_wdata[8*k +: 8];
            end
          end else begin
            m_val = 32'd0;
            for (int k = 0; k < int'(m_nb); k++) begin
              m_val = m_val | (32'(ref_mem[m_word*4 + m_off + k]) << (8*k));
            end
            if (!req_unsigned && m_nb < 4 && m_val[8*m_nb-1]) begin
              m_val = m_val | ~((32'd1 << (8*m_nb)) - 1);
            end
            m_e.rdata = m_val;
          end
        end
        exp_q.push_back(m_e);
      end
    end
  end

  task automatic drive(input logic v, input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input logic rr);
    @(posedge clk);
    #1;
    req_valid    = v;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    rsp_ready    = rr;
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < int'(n); i++) drive(1'b0, 1'b0, 32'd0, 2'b10, 1'b0, 32'd0, 1'b1);
  endtask

  int unsigned acc0, pop0;
  logic [31:0] r_addr;
  logic [1:0]  r_size;

  initial begin
    rst          = 1'b0;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_addr     = 32'h0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_wdata    = 32'h1234_5678;
    rsp_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("reset_rsp_error", 32'(rsp_error), 32'd0);
    check_eq("reset_req_ready", 32'(req_ready), 32'd1);
    check_eq("reset_ram_en", 32'(ram_en), 32'd0);
    check_eq("reset_ram_we", 32'(ram_we), 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;

    // Word store then load
    drive(1'b1, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b1);
    drive(1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b1);
    // Byte store 0x80 at 0x13, signed then unsigned loads
    drive(1'b1, 1'b1, 32'h13, 2'b00, 1'b0, 32'h0000_0080, 1'b1);
    drive(1'b1, 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 1'b1);
    // Misaligned half then word load
    drive(1'b1, 1'b0, 32'h21, 2'b01, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h24, 2'b10, 1'b0, 32'h0, 1'b1);
    // Illegal size, half loads on both lanes, upper-range address
    drive(1'b1, 1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h10, 2'b01, 1'b1, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0001_0000, 2'b10, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0001_0010, 2'b10, 1'b0, 32'h0, 1'b1);
    idle(5);

    // Stall: continuous loads with the consumer blocked
    acc0 = n_acc;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 32'(i * 4), 2'b10, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    check_eq("stall_accepts", n_acc - acc0, Depth);
    check_eq("stall_req_ready", 32'(req_ready), 32'd0);
    pop0 = n_pop;
    idle(6);
    @(negedge clk);
    #1;
    check_eq("stall_drained", n_pop - pop0, Depth);

    // Reset with two loads in flight
    drive(1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h14, 2'b10, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("midreset_ram_en", 32'(ram_en), 32'd0);
    exp_q.delete();
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("postreset_req_ready", 32'(req_ready), 32'd1);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r_addr = $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) r_addr = r_addr | ($urandom() << (Aw + 2));
      r_size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (r_size != 2'b11 && $urandom_range(0, 4) != 0) begin
        r_addr = r_addr & ~((32'd1 << r_size) - 1);
      end
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), r_addr, r_size,
            1'($urandom_range(0, 1)), $urandom(), $urandom_range(0, 3) != 0);
    end
    idle(8);
    @(negedge clk);
    #1;
    check_eq("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_access_unit.md
# ram_access_unit

Bridges the core's load/store request channel onto one port of the byte-write data RAM. Decodes size and offset into column write enables and replicated write data, and tracks in-flight accesses across the RAM read latency. Aligns and extends load data, and buffers responses so the consumer can stall without losing data. One instance per RAM port, directly upstream of the RAM.

## Interface
- RAM_DEPTH, 16384: RAM words; AW = $clog2(RAM_DEPTH).
- LATENCY, 1: RAM read latency in cycles (1 or 2); must match the RAM instance.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and flagged as an error.
- req_unsigned  in  1  zero-extend load data (ignored for stores/word).
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  32  aligned/extended load data; 0 for stores and errors.
- rsp_error  out  1  misaligned, illegal size or out-of-range access.
- ram_addr  out  AW  word address = req_addr[AW+1:2].
- ram_din  out  32  replicated store data.
- ram_en  out  1  port enable.
- ram_we  out  4  column write enables.
- ram_dout  in  32  RAM read data.

## Operation
- Accept = req_valid & req_ready. Error when req_size = 11, size 01 with addr[0] = 1, or size 10 with addr[1:0] ≠ 0 (misaligned), or out of range (see Configuration).
- ram_en = accept & ~error; ram_we = ram_en & req_we ? mask : 0. The RAM side is combinational from the request.
- Write masks: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111. ram_din: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Every accept, including errors and stores, pushes a tag {offset[1:0], size, unsigned, we, error} into a LATENCY-deep shift pipeline. Exactly one response is produced per accepted request, in order.
- Load format: byte selects lane addr[1:0], half selects lane addr[1]; sign-extend unless req_unsigned; word passes through.
- Response FIFO depth D = LATENCY+1. outstanding = in-flight tags + FIFO count. req_ready = outstanding < D (registered state only, no path from rsp_ready).
- Bypass: when the FIFO is empty and a tag exits the pipeline, the response is driven directly. If rsp_ready is low, the response is written into the FIFO in the same cycle, capturing ram_dout while it is valid. A FIFO push and pop in the same cycle are allowed at any count.

## Timing
- Reset values: rsp_valid 0, rsp_rdata 0, rsp_error 0, pipeline empty, FIFO empty, req_ready 1. ram_en/ram_we are 0 while in reset.
- Load accepted in cycle T: rsp_valid in cycle T+LATENCY with rsp_ready high; back-to-back throughput of 1 per cycle is sustained.
- Store accepted in T: RAM written at the T edge; response in T+LATENCY.
- Stall: with rsp_ready low, at most D requests are accepted, then req_ready drops. It rises the cycle after the first pop.
- Reset mid-operation: in-flight tags and FIFO are discarded with no response. Stores already presented at a clock edge remain written.
- Outputs hold stable while rsp_valid & ~rsp_ready.

## Configuration
- AURORA_RAM_RANGE_CHECK_EN defined: req_addr[31:AW+2] ≠ 0 sets error, the RAM is not enabled, and rsp_error = 1.
- Not defined: upper address bits are ignored, and the address wraps modulo RAM_DEPTH words. Only misalignment and illegal size produce errors.

## Test plan
- Store word 0xDEADBEEF at 0x10, load word 0x10 -> ram_we 1111, rsp_rdata 0xDEADBEEF, rsp_error 0 at T+LATENCY.
- Store byte 0x80 at 0x13, then signed and unsigned byte load at 0x13 -> ram_we 1000, ram_din 0x80808080; rdata 0xFFFFFF80 then 0x00000080.
- Half load at 0x21 -> ram_en 0, rsp_error 1, rdata 0; a following word load at 0x24 is answered next and in order.
- rsp_ready held 0 with continuous loads, LATENCY=2 -> exactly 3 accepts, then req_ready 0. Release -> 3 responses in order, no gaps or loss.
- With the macro defined, load at 0x0001_0000 (RAM_DEPTH=16384) -> rsp_error 1, ram_en 0. Without the macro -> reads word 0, rsp_error 0.
- Assert rst low with 2 loads in flight -> rsp_valid 0 immediately, req_ready 1 after release, no stale response.
